// File: rtl/flasher_pkg.sv
// Shared constants, reset values, FSM state encoding and LED helper for the
// I2C-controlled LED flasher.
package flasher_pkg;

    localparam int I2C_DATA_BITS = 6;

    // Byte tags carried in byte[7:6]
    localparam logic [1:0] A_ADDR = 2'b00;
    localparam logic [1:0] D_ADDR = 2'b01;

    // Register addresses
    localparam logic [I2C_DATA_BITS-1:0] REG_RATE = 6'd1;
    localparam logic [I2C_DATA_BITS-1:0] REG_MODE = 6'd2;

    // Reset values
    localparam logic [I2C_DATA_BITS-1:0] PTR_RST   = 6'd0;
    localparam logic [I2C_DATA_BITS-1:0] RATE_RST  = 6'd20;
    localparam logic [I2C_DATA_BITS-1:0] MODE_RST  = 6'd0;
    localparam logic                     PHASE_RST = 1'b0;
    localparam logic [1:0]               LED_RST   = 2'b10;   // {LEDR, LEDG}

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4
    } i2c_state_e;

    // LED pattern {LEDR, LEDG} for a given MODE value and blink phase.
    function automatic logic [1:0] led_pattern(input logic [I2C_DATA_BITS-1:0] mode,
                                               input logic phase);
        logic [1:0] pat;
        if (mode[1]) begin
            pat = 2'b00;
        end else if (mode[0]) begin
            pat = {phase, phase};
        end else begin
            pat = {~phase, phase};
        end
        return pat;
    endfunction

endpackage

// File: rtl/flasher_ctl_i2c_byte_slave.sv
// Write-only I2C byte receiver: input synchronizers, START/STOP detection,
// 8-bit shifter and ACK drive. Emits one byte_valid pulse per data byte.
// Build option: FLASHER_LSB_FIRST_EN shifts bytes LSB-first instead of the
// standard MSB-first order.
module i2c_byte_slave
    import flasher_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h41
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_low,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       addr_match
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;

    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;

    i2c_state_e state_r, state_n;
    logic [3:0] bit_cnt_r, bit_cnt_n;
    logic [7:0] shift_r, shift_n;
    logic       sda_low_r, sda_low_n;
    logic       valid_r, valid_n;
    logic [7:0] byte_r, byte_n;
    logic       match_r, match_n;

    // Insert one received bit into the shift register in the configured order.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
`ifdef FLASHER_LSB_FIRST_EN
        return {bit_in, cur[7:1]};
`else
        return {cur[6:0], bit_in};
`endif
    endfunction

    // Two-flop synchronizers plus one history stage for edge detection; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda_in};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    assign scl_rise_s = scl_sync_r[1] & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r[1] & scl_prev_r;
    assign start_s    = scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
    assign stop_s     = scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];

    // Protocol state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'd0;
            sda_low_r <= 1'b0;
            valid_r   <= 1'b0;
            byte_r    <= 8'd0;
            match_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            sda_low_r <= sda_low_n;
            valid_r   <= valid_n;
            byte_r    <= byte_n;
            match_r   <= match_n;
        end
    end

    // Next-state logic: START/STOP abort anything in progress, otherwise walk the byte/ACK sequence.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        sda_low_n = sda_low_r;
        valid_n   = 1'b0;
        byte_n    = byte_r;
        match_n   = match_r;

        if (start_s) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            sda_low_n = 1'b0;
            match_n   = 1'b0;
        end else if (stop_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            sda_low_n = 1'b0;
            match_n   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_low_n = 1'b0;
                end
                ST_ADDR, ST_DATA: begin
                    if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
                        shift_n   = shift_in(shift_r, sda_sync_r[1]);
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                        if (state_r == ST_DATA) begin
                            state_n   = ST_DATA_ACK;
                            sda_low_n = 1'b1;
                        end else if ((shift_r[7:1] == I2C_ADDR) && (shift_r[0] == 1'b0)) begin
                            state_n   = ST_ADDR_ACK;
                            sda_low_n = 1'b1;
                            match_n   = 1'b1;
                        end else begin
                            state_n   = ST_IDLE;
                            sda_low_n = 1'b0;
                            match_n   = 1'b0;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        state_n   = ST_DATA;
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                    end else begin
                        sda_low_n = 1'b1;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_rise_s) begin
                        valid_n = 1'b1;
                        byte_n  = shift_r;
                    end else if (scl_fall_s) begin
                        state_n   = ST_DATA;
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                    end else begin
                        sda_low_n = 1'b1;
                    end
                end
                default: begin
                    state_n   = ST_IDLE;
                    sda_low_n = 1'b0;
                    match_n   = 1'b0;
                end
            endcase
        end
    end

    assign sda_low    = sda_low_r;
    assign byte_valid = valid_r;
    assign byte_data  = byte_r;
    assign addr_match = match_r;

endmodule

// File: rtl/flasher_ctl.sv
// I2C-controlled red/green LED flasher: register file (pointer, RATE, MODE)
// written through a write-only I2C slave, and a tick-based blink engine.
// Build option: FLASHER_LSB_FIRST_EN selects LSB-first byte shifting.
module flasher_ctl
    import flasher_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h41,
    parameter int         TICK_CYCLES = 20000
) (
    input  logic CLK,
    input  logic GSR,
    input  logic SCL,
    inout  wire  SDA,
    output logic LEDR,
    output logic LEDG
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic                     sda_low_s;
    logic                     byte_valid_s;
    logic [7:0]               byte_s;
    logic                     addr_match_s;

    logic [I2C_DATA_BITS-1:0] ptr_r;
    logic [I2C_DATA_BITS-1:0] rate_r;
    logic [I2C_DATA_BITS-1:0] mode_r;

    logic [TICK_W-1:0]        tick_cnt_r;
    logic                     tick_s;
    logic [I2C_DATA_BITS-1:0] half_cnt_r;
    logic                     phase_r;

    i2c_byte_slave #(
        .I2C_ADDR (I2C_ADDR)
    ) u_slave (
        .clk        (CLK),
        .rst        (GSR),
        .scl        (SCL),
        .sda_in     (SDA),
        .sda_low    (sda_low_s),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_s),
        .addr_match (addr_match_s)
    );

    // Open-drain: only ever pull low or release.
    assign SDA = sda_low_s ? 1'b0 : 1'bz;

    // Decode each received data byte into a pointer load or a register write.
    always_ff @(posedge CLK or posedge GSR) begin
        if (GSR) begin
            ptr_r  <= PTR_RST;
            rate_r <= RATE_RST;
            mode_r <= MODE_RST;
        end else if (byte_valid_s && addr_match_s) begin
            case (byte_s[7:6])
                A_ADDR: ptr_r <= byte_s[5:0];
                D_ADDR: begin
                    case (ptr_r)
                        REG_RATE: rate_r <= byte_s[5:0];
                        REG_MODE: mode_r <= byte_s[5:0];
                        default:  ptr_r  <= ptr_r;
                    endcase
                end
                default: ptr_r <= ptr_r;
            endcase
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_W'(TICK_CYCLES - 1));

    // Tick prescaler: one tick every TICK_CYCLES clocks.
    always_ff @(posedge CLK or posedge GSR) begin
        if (GSR) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Half-period counter; >= lets a lowered RATE take effect on the very next tick.
    always_ff @(posedge CLK or posedge GSR) begin
        if (GSR) begin
            half_cnt_r <= 6'd0;
            phase_r    <= PHASE_RST;
        end else if (tick_s) begin
            if (half_cnt_r >= rate_r) begin
                half_cnt_r <= 6'd0;
                phase_r    <= ~phase_r;
            end else begin
                half_cnt_r <= half_cnt_r + 6'd1;
            end
        end else begin
            half_cnt_r <= half_cnt_r;
        end
    end

    // Registered LED drivers, following MODE one clock after it changes.
    always_ff @(posedge CLK or posedge GSR) begin
        if (GSR) begin
            {LEDR, LEDG} <= LED_RST;
        end else begin
            {LEDR, LEDG} <= led_pattern(mode_r, phase_r);
        end
    end

endmodule

// File: tb/tb_flasher_ctl.sv
// Self-checking bench for flasher_ctl: bit-banged I2C master, table of
// transactions, directed corner sequences and randomized transfers checked
// against a register-level model of the flasher.
module tb_flasher_ctl;

    localparam int         TK  = 10;      // TICK_CYCLES used for the DUT
    localparam int         Q   = 6;       // quarter SCL period in CLK cycles
    localparam logic [6:0] DEV = 7'h41;

    logic clk = 1'b0;
    logic gsr;
    logic scl;
    logic tb_sda_low;
    wire  sda_w;
    logic ledr;
    logic ledg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the register file as the host sees it.
    logic [5:0] m_regs [64];
    logic [5:0] m_ptr;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [15:0] data;     // {second byte, first byte}
        logic        exp_ack;
        logic [5:0]  exp_mode;
    } vec_t;

    vec_t vecs [9];

    assign sda_w = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    flasher_ctl #(
        .I2C_ADDR    (DEV),
        .TICK_CYCLES (TK)
    ) dut (
        .CLK  (clk),
        .GSR  (gsr),
        .SCL  (scl),
        .SDA  (sda_w),
        .LEDR (ledr),
        .LEDG (ledg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 6'd0;
        m_regs[1] = 6'd20;
        m_ptr     = 6'd0;
    endtask

    task automatic m_apply(input logic [7:0] b);
        if (b[7:6] == 2'b00) begin
            m_ptr = b[5:0];
        end else if (b[7:6] == 2'b01 && (m_ptr == 6'd1 || m_ptr == 6'd2)) begin
            m_regs[m_ptr] = b[5:0];
        end
    endtask

    // LED relationship required by a MODE value.
    task automatic check_leds(input string name, input logic [5:0] md);
        if (md[1]) begin
            check({name, " leds off"}, {30'd0, ledr, ledg}, 32'd0);
        end else if (md[0]) begin
            check({name, " leds sync"}, {31'd0, ledr ^ ledg}, 32'd0);
        end else begin
            check({name, " leds alternate"}, {31'd0, ledr ^ ledg}, 32'd1);
        end
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        tb_sda_low = 1'b1;
        wq(Q);
        scl = 1'b0;
        wq(Q);
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        tb_sda_low = 1'b0;
        wq(Q);
    endtask

    task automatic send_bit(input logic b);
        tb_sda_low = ~b;
        wq(Q);
        scl = 1'b1;
        wq(2 * Q);
        scl = 1'b0;
        wq(Q);
    endtask

    task automatic send_bits8(input logic [7:0] b);
`ifdef FLASHER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`else
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits8(b);
        tb_sda_low = 1'b0;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        ack = (sda_w === 1'b0);
        wq(Q);
        scl = 1'b0;
        wq(Q);
    endtask

    // Full write transfer of n data bytes; every ACK is checked against exp_ack.
    task automatic xfer(input string name, input logic [6:0] a, input logic rw,
                        input int n, input logic [23:0] data, input logic exp_ack);
        logic ack;
        logic [7:0] b;
        i2c_start();
        send_byte({a, rw}, ack);
        check({name, " addr ack"}, {31'd0, ack}, {31'd0, exp_ack});
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            send_byte(b, ack);
            check({name, " data ack"}, {31'd0, ack}, {31'd0, exp_ack});
            if (a == DEV && !rw) m_apply(b);
        end
        i2c_stop();
        wq(2);
    endtask

    // Wait for a LEDG edge, then count clocks to the next one.
    task automatic measure_half(input string name, input int exp_cycles);
        logic prev;
        int   cnt;
        int   budget;
        bit   seen;
        budget = 4 * 64 * TK + 100;
        seen   = 1'b0;
        prev   = ledg;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (ledg !== prev) seen = 1'b1;
        end
        if (!seen) begin
            check({name, " first edge timeout"}, 32'd0, 32'd1);
        end else begin
            prev = ledg;
            cnt  = 0;
            seen = 1'b0;
            for (int i = 0; i < budget && !seen; i++) begin
                @(posedge clk); #1;
                cnt++;
                if (ledg !== prev) seen = 1'b1;
            end
            if (!seen) check({name, " second edge timeout"}, 32'd0, 32'd1);
            else       check({name, " half period"}, cnt, exp_cycles);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        bit         seen;
        logic [6:0] ra;
        logic       rrw;
        int         rn;
        logic [23:0] rd;
        logic [1:0] tag;
        logic       ack;

        vecs[0] = '{addr: DEV,   rw: 1'b0, data: 16'h41_02, exp_ack: 1'b1, exp_mode: 6'h01};
        vecs[1] = '{addr: 7'h20, rw: 1'b0, data: 16'h40_02, exp_ack: 1'b0, exp_mode: 6'h01};
        vecs[2] = '{addr: DEV,   rw: 1'b1, data: 16'h40_02, exp_ack: 1'b0, exp_mode: 6'h01};
        vecs[3] = '{addr: DEV,   rw: 1'b0, data: 16'h42_02, exp_ack: 1'b1, exp_mode: 6'h02};
        vecs[4] = '{addr: DEV,   rw: 1'b0, data: 16'h40_05, exp_ack: 1'b1, exp_mode: 6'h02};
        vecs[5] = '{addr: DEV,   rw: 1'b0, data: 16'hC0_02, exp_ack: 1'b1, exp_mode: 6'h02};
        vecs[6] = '{addr: DEV,   rw: 1'b0, data: 16'h40_80, exp_ack: 1'b1, exp_mode: 6'h00};
        vecs[7] = '{addr: DEV,   rw: 1'b0, data: 16'h7D_02, exp_ack: 1'b1, exp_mode: 6'h3D};
        vecs[8] = '{addr: DEV,   rw: 1'b0, data: 16'h7C_02, exp_ack: 1'b1, exp_mode: 6'h3C};

        // Reset state
        gsr        = 1'b1;
        scl        = 1'b1;
        tb_sda_low = 1'b0;
        m_reset();
        wq(3);
        check("reset LEDR", {31'd0, ledr}, 32'd1);
        check("reset LEDG", {31'd0, ledg}, 32'd0);
        check("reset SDA released", {31'd0, sda_w}, 32'd1);
        gsr = 1'b0;

        // First phase toggle after 21 ticks (plus the LED register stage)
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 * TK && !seen; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (ledr === 1'b0) seen = 1'b1;
        end
        check("first toggle window", {31'd0, (seen && cnt >= 21 * TK && cnt <= 21 * TK + 2)}, 32'd1);
        check("first toggle LEDG", {31'd0, ledg}, 32'd1);

        // Table of transfers
        foreach (vecs[i]) begin
            xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, 2,
                 {8'h00, vecs[i].data}, vecs[i].exp_ack);
            check_leds($sformatf("vec%0d", i), vecs[i].exp_mode);
        end

        // RATE = 3 gives a 4-tick half period
        xfer("rate3", DEV, 1'b0, 2, 24'h00_43_01, 1'b1);
        measure_half("rate3", 4 * TK);

        // MODE bit1 forces both LEDs off, and they stay off
        xfer("mode off", DEV, 1'b0, 2, 24'h00_42_02, 1'b1);
        check_leds("mode off", m_regs[2]);
        wq(9 * TK);
        check_leds("mode off later", m_regs[2]);

        // STOP after four data bits discards the partial byte
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        check("partial addr ack", {31'd0, ack}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_stop();
        wq(2);
        check_leds("after partial", m_regs[2]);
        xfer("post partial", DEV, 1'b0, 2, 24'h00_41_02, 1'b1);
        check_leds("post partial", m_regs[2]);

        // Randomized transfers against the register model
        for (int it = 0; it < 20; it++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
            rrw = ($urandom_range(0, 4) == 0);
            rn  = $urandom_range(1, 3);
            rd  = 24'd0;
            for (int k = 0; k < 3; k++) begin
                tag = 2'($urandom_range(0, 3));
                if (tag == 2'b00) rd[8*k +: 8] = {tag, 6'($urandom_range(0, 3))};
                else              rd[8*k +: 8] = {tag, 6'($urandom_range(0, 63))};
            end
            xfer($sformatf("rand%0d", it), ra, rrw, rn, rd, (ra == DEV) && !rrw);
            check_leds($sformatf("rand%0d", it), m_regs[2]);
        end

        // Alternating mode, then verify the model's RATE through the blink period
        xfer("rand final mode0", DEV, 1'b0, 2, 24'h00_40_02, 1'b1);
        check_leds("rand final mode0", m_regs[2]);
        measure_half("rand final rate", (int'(m_regs[1]) + 1) * TK);

        // GSR during the address ACK releases SDA at once and restores reset values
        i2c_start();
        send_bits8({DEV, 1'b0});
        tb_sda_low = 1'b0;
        wq(Q);
        check("ack driven before gsr", {31'd0, sda_w}, 32'd0);
        gsr = 1'b1;
        #1;
        check("gsr releases SDA", {31'd0, sda_w}, 32'd1);
        check("gsr LEDR", {31'd0, ledr}, 32'd1);
        check("gsr LEDG", {31'd0, ledg}, 32'd0);
        scl = 1'b1;
        wq(4);
        gsr = 1'b0;
        m_reset();
        measure_half("post gsr rate", 21 * TK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
